// File: rtl/obi_tile_demux.sv
// OBI 1-to-N_SBR address demultiplexer with in-order responses and a built-in decode-error responder.
// Outstanding transactions may only target one subordinate at a time; switching target waits for a drain.
module obi_tile_demux #(
    parameter int N_SBR      = 2,
    parameter int N_RULE     = 2,
    parameter int N_MAX_TRAN = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int AID_W      = 1,
    localparam int IDX_W     = (N_SBR > 1) ? $clog2(N_SBR) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_RULE*IDX_W-1:0]    rule_idx_i,
    input  logic [N_RULE*ADDR_W-1:0]   rule_start_i,
    input  logic [N_RULE*ADDR_W-1:0]   rule_end_i,
    input  logic                       mgr_req_i,
    output logic                       mgr_gnt_o,
    input  logic [ADDR_W-1:0]          mgr_addr_i,
    input  logic                       mgr_we_i,
    input  logic [DATA_W/8-1:0]        mgr_be_i,
    input  logic [DATA_W-1:0]          mgr_wdata_i,
    input  logic [AID_W-1:0]           mgr_aid_i,
    output logic                       mgr_rvalid_o,
    output logic [DATA_W-1:0]          mgr_rdata_o,
    output logic                       mgr_err_o,
    output logic [AID_W-1:0]           mgr_rid_o,
    output logic [N_SBR-1:0]           sbr_req_o,
    input  logic [N_SBR-1:0]           sbr_gnt_i,
    output logic [ADDR_W-1:0]          sbr_addr_o,
    output logic                       sbr_we_o,
    output logic [DATA_W/8-1:0]        sbr_be_o,
    output logic [DATA_W-1:0]          sbr_wdata_o,
    output logic [AID_W-1:0]           sbr_aid_o,
    input  logic [N_SBR-1:0]           sbr_rvalid_i,
    input  logic [N_SBR*DATA_W-1:0]    sbr_rdata_i,
    input  logic [N_SBR-1:0]           sbr_err_i,
    input  logic [N_SBR*AID_W-1:0]     sbr_rid_i
);

    localparam int TGT_W = $clog2(N_SBR + 1);
    localparam int CNT_W = $clog2(N_MAX_TRAN + 1);
    localparam logic [TGT_W-1:0]  TGT_ERR  = TGT_W'(N_SBR);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(N_MAX_TRAN);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hBADCAB1E);

    logic [TGT_W-1:0]  sel;
    logic [TGT_W-1:0]  last_sel_q, last_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_rvalid_q, err_rvalid_d;
    logic [AID_W-1:0]  err_rid_q, err_rid_d;
    logic              accept;
    logic              grant;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [AID_W-1:0]  rsp_rid;
    logic              stray_rvalid;

    // Walk rules from highest to lowest index so the lowest matching rule wins.
    always_comb begin
        sel = TGT_ERR;
        for (int i = N_RULE - 1; i >= 0; i--) begin
            if ((mgr_addr_i >= rule_start_i[i*ADDR_W +: ADDR_W]) &&
                (mgr_addr_i <  rule_end_i[i*ADDR_W +: ADDR_W])) begin
                sel = TGT_W'(rule_idx_i[i*IDX_W +: IDX_W]);
            end
        end
    end

    assign accept = (cnt_q < CNT_MAX) && ((cnt_q == '0) || (sel == last_sel_q));

    always_comb begin
        sbr_req_o = '0;
        grant     = 1'b0;
        if (sel == TGT_ERR) begin
            grant = mgr_req_i & accept;
        end
        for (int s = 0; s < N_SBR; s++) begin
            if (sel == TGT_W'(s)) begin
                sbr_req_o[s] = mgr_req_i & accept;
                grant        = mgr_req_i & sbr_gnt_i[s] & accept;
            end
        end
    end

    assign mgr_gnt_o   = grant;
    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign sbr_aid_o   = mgr_aid_i;

    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        rsp_rid   = '0;
        if (last_sel_q == TGT_ERR) begin
            rsp_valid = err_rvalid_q;
            rsp_data  = ERR_DATA;
            rsp_err   = 1'b1;
            rsp_rid   = err_rid_q;
        end
        for (int s = 0; s < N_SBR; s++) begin
            if (last_sel_q == TGT_W'(s)) begin
                rsp_valid = sbr_rvalid_i[s];
                rsp_data  = sbr_rdata_i[s*DATA_W +: DATA_W];
                rsp_err   = sbr_err_i[s];
                rsp_rid   = sbr_rid_i[s*AID_W +: AID_W];
            end
        end
    end

    // With nothing outstanding, any response is a leftover from before a reset and is dropped.
    always_comb begin
        mgr_rvalid_o = rsp_valid & (cnt_q != '0);
        mgr_rdata_o  = mgr_rvalid_o ? rsp_data : '0;
        mgr_err_o    = mgr_rvalid_o & rsp_err;
        mgr_rid_o    = mgr_rvalid_o ? rsp_rid : '0;
    end

    always_comb begin
        cnt_d        = cnt_q + CNT_W'(grant) - CNT_W'(mgr_rvalid_o);
        last_sel_d   = grant ? sel : last_sel_q;
        err_rvalid_d = grant && (sel == TGT_ERR);
        err_rid_d    = (grant && (sel == TGT_ERR)) ? mgr_aid_i : err_rid_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            last_sel_q   <= '0;
            err_rvalid_q <= 1'b0;
            err_rid_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            last_sel_q   <= last_sel_d;
            err_rvalid_q <= err_rvalid_d;
            err_rid_q    <= err_rid_d;
        end
    end

    always_comb begin
        stray_rvalid = 1'b0;
        for (int s = 0; s < N_SBR; s++) begin
            if (sbr_rvalid_i[s] && (last_sel_q != TGT_W'(s)) && (cnt_q != '0)) begin
                stray_rvalid = 1'b1;
            end
        end
    end

    a_cnt_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CNT_MAX);
    a_no_ovf:     assert property (@(posedge clk_i) disable iff (!rst_ni) !((cnt_q == CNT_MAX) && grant));
    a_no_udf:     assert property (@(posedge clk_i) disable iff (!rst_ni) !((cnt_q == '0) && mgr_rvalid_o));
    a_no_stray:   assert property (@(posedge clk_i) disable iff (!rst_ni) !stray_rvalid);

endmodule
